// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the iMem boot loader: FSM state encoding,
// word geometry and header byte order.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } boot_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = 16;

    // Header is sent high byte first.
    localparam int unsigned HDR_HI_LSB = 8;
    localparam int unsigned HDR_LO_LSB = 0;

    function automatic logic [CNT_W-1:0] hdr_count(input logic [7:0] hi, input logic [7:0] lo);
        return (CNT_W'(hi) << HDR_HI_LSB) | (CNT_W'(lo) << HDR_LO_LSB);
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes MSB-first and flags the
// byte that completes a 32-bit word.
module boot_word_assembler (
    input  logic        clk,
    input  logic        resetn,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);
    import imem_boot_pkg::*;

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [23:0]      sh;
    logic [IDX_W-1:0] idx;

    // The completing byte is merged combinationally so the caller can
    // register the whole word on the same edge that accepts that byte.
    assign word       = {sh, byte_in};
    assign word_valid = byte_en && (idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh  <= '0;
            idx <= '0;
        end else if (byte_en) begin
            sh  <= {sh[15:0], byte_in};
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Length-prefixed byte-stream loader for the CPU instruction memory; holds
// the CPU in reset until the image is in. IMEM_BOOT_CSUM_EN adds a trailing XOR checksum.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_resetn,
    output logic              load_done,
    output logic              load_err,
    output logic              ovf
);
    import imem_boot_pkg::*;

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    boot_state_t      state;
    logic [7:0]       cnt_hi;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] hdr;
    logic             accept;
    logic             asm_en;
    logic             asm_valid;
    logic [31:0]      asm_word;
    logic             last_word;
    logic             go_post;

    always_comb begin
        accept    = in_valid && in_ready;
        hdr       = CNT_W'(hdr_count(cnt_hi, in_data));
        asm_en    = accept && (state == DATA);
        last_word = (word_idx + CNT_W'(1)) == count;
        go_post   = (accept && (state == HDR_LO) && (hdr == '0)) || (asm_valid && last_word);
    end

    boot_word_assembler u_asm (
        .clk        (clk),
        .resetn     (resetn),
        .byte_en    (asm_en),
        .byte_in    (in_data),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

`ifdef IMEM_BOOT_CSUM_EN
    logic [7:0] xr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xr <= '0;
        end else if (accept && (state == HDR_HI || state == HDR_LO || state == DATA)) begin
            xr <= xr ^ in_data;
        end
    end
`else
    assign load_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= HDR_HI;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_resetn <= 1'b0;
            load_done  <= 1'b0;
            ovf        <= 1'b0;
            cnt_hi     <= '0;
            count      <= '0;
            word_idx   <= '0;
`ifdef IMEM_BOOT_CSUM_EN
            load_err   <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR_HI: begin
                    if (accept) begin
                        cnt_hi <= in_data;
                        state  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        count <= hdr;
                        if (32'(hdr) > DEPTH) ovf <= 1'b1;
                        if (hdr != '0) state <= DATA;
                    end
                end
                DATA: begin
                    if (asm_valid) begin
                        // Words past the end of iMem are swallowed; the address holds.
                        if (32'(word_idx) < DEPTH) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx[ADDR_W-1:0];
                            imem_wdata <= asm_word;
                        end
                        word_idx <= word_idx + CNT_W'(1);
                    end
                end
`ifdef IMEM_BOOT_CSUM_EN
                CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if ((xr ^ in_data) == 8'h00) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    // Release only once the final write strobe has dropped.
                    if (!imem_we) cpu_resetn <= 1'b1;
                end
                default: ;
            endcase

            if (go_post) begin
`ifdef IMEM_BOOT_CSUM_EN
                state <= CSUM;
`else
                state     <= DONE;
                in_ready  <= 1'b0;
                load_done <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (ADDR_W=8 and ADDR_W=2
// instances sharing one stream); IMEM_BOOT_CSUM_EN selects the checksum scenarios.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn   = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;

    logic        in_ready, imem_we, cpu_resetn, load_done, load_err, ovf;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    logic        s_in_ready, s_imem_we, s_cpu_resetn, s_load_done, s_load_err, s_ovf;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;

    imem_boot_loader #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_resetn(cpu_resetn), .load_done(load_done),
        .load_err(load_err), .ovf(ovf)
    );

    imem_boot_loader #(.ADDR_W(2), .CNT_W(16)) dut_small (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .cpu_resetn(s_cpu_resetn), .load_done(s_load_done),
        .load_err(s_load_err), .ovf(s_ovf)
    );

`ifdef IMEM_BOOT_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit sel    = 1'b0;

    logic [7:0]  b_addr[$];
    logic [31:0] b_data[$];
    int          b_edge[$];
    logic [1:0]  s_addr[$];
    logic [31:0] s_data[$];
    bit          rise_seen = 1'b0;
    int          rise_edge = 0;
    int          early     = 0;
    int          acc_edge  = 0;
    int          last_edge = 0;
    logic [7:0]  xsum      = 8'h00;

    logic [31:0] W2 [8] = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] W5 [8] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3,
                            32'hE0E1E2E3, 32'h0, 32'h0, 32'h0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            b_addr.push_back(imem_addr);
            b_data.push_back(imem_wdata);
            b_edge.push_back(cyc);
        end
        if (s_imem_we) begin
            s_addr.push_back(s_imem_addr);
            s_data.push_back(s_imem_wdata);
        end
        if (cpu_resetn && !rise_seen) begin
            rise_seen = 1'b1;
            rise_edge = cyc;
        end
        if (cpu_resetn && !load_done) early++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        xsum     = xsum ^ b;
        while (!(sel ? s_in_ready : in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((sel ? s_in_ready : in_ready) !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout: byte %02h in_ready=0 required 1", b);
        end
        @(posedge clk);
        @(negedge clk);
        acc_edge = cyc;
    endtask

    task automatic send_image(input int n, input logic [31:0] w [8], input bit stall);
        logic [31:0] cur;
        logic [7:0]  cs;
        xsum = 8'h00;
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int k = 0; k < n; k++) begin
            cur = w[k];
            for (int j = 0; j < 4; j++) begin
                if (stall && k == 0 && j == 2) begin
                    in_valid = 1'b0;
                    repeat (3) @(negedge clk);
                end
                send_byte(cur[31:24]);
                cur = {cur[23:0], 8'h00};
            end
        end
        last_edge = acc_edge;
`ifdef IMEM_BOOT_CSUM_EN
        cs = xsum;
        send_byte(cs);
`else
        cs = 8'h00;
`endif
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn   = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        b_addr.delete();
        b_data.delete();
        b_edge.delete();
        s_addr.delete();
        s_data.delete();
        rise_seen = 1'b0;
        early     = 0;
        resetn    = 1'b1;
    endtask

    task automatic check_two_words(input string tag);
        checks++;
        if (b_addr.size() !== 2) begin
            fails++;
            $display("FAIL %s_wr_count: got %0d required 2", tag, b_addr.size());
        end else begin
            checks += 5;
            if (b_addr[0] !== 8'd0)         begin fails++; $display("FAIL %s_addr0: got %0d required 0", tag, b_addr[0]); end
            if (b_data[0] !== 32'h12345678) begin fails++; $display("FAIL %s_data0: got %08h required 12345678", tag, b_data[0]); end
            if (b_addr[1] !== 8'd1)         begin fails++; $display("FAIL %s_addr1: got %0d required 1", tag, b_addr[1]); end
            if (b_data[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL %s_data1: got %08h required deadbeef", tag, b_data[1]); end
            // Write strobe is visible in the cycle right after the last byte's edge.
            if (b_edge[1] !== last_edge)    begin fails++; $display("FAIL %s_we_latency: got edge %0d required %0d", tag, b_edge[1], last_edge); end
        end
        checks += 4;
        if (!rise_seen || rise_edge !== last_edge + 2) begin
            fails++;
            $display("FAIL %s_cpu_release: seen=%0d edge %0d required %0d", tag, rise_seen, rise_edge, last_edge + 2);
        end
        if (load_done !== 1'b1) begin fails++; $display("FAIL %s_load_done: got %b required 1", tag, load_done); end
        if (in_ready !== 1'b0)  begin fails++; $display("FAIL %s_in_ready: got %b required 0", tag, in_ready); end
        if (early !== 0)        begin fails++; $display("FAIL %s_early_release: got %0d required 0", tag, early); end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 9;
        if (in_ready !== 1'b1)       begin fails++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        if (imem_we !== 1'b0)        begin fails++; $display("FAIL rst_imem_we: got %b required 0", imem_we); end
        if (imem_addr !== 8'd0)      begin fails++; $display("FAIL rst_imem_addr: got %0d required 0", imem_addr); end
        if (imem_wdata !== 32'd0)    begin fails++; $display("FAIL rst_imem_wdata: got %08h required 0", imem_wdata); end
        if (cpu_resetn !== 1'b0)     begin fails++; $display("FAIL rst_cpu_resetn: got %b required 0", cpu_resetn); end
        if (load_done !== 1'b0)      begin fails++; $display("FAIL rst_load_done: got %b required 0", load_done); end
        if (load_err !== 1'b0)       begin fails++; $display("FAIL rst_load_err: got %b required 0", load_err); end
        if (ovf !== 1'b0)            begin fails++; $display("FAIL rst_ovf: got %b required 0", ovf); end
        if (s_in_ready !== 1'b1)     begin fails++; $display("FAIL rst_s_in_ready: got %b required 1", s_in_ready); end
    endtask

    task automatic test_two_words();
        sel = 1'b0;
        do_reset();
        send_image(2, W2, 1'b0);
        repeat (5) @(negedge clk);
        check_two_words("img2");
        checks++;
        if (ovf !== 1'b0) begin fails++; $display("FAIL img2_ovf: got %b required 0", ovf); end
    endtask

    task automatic test_empty();
        sel = 1'b0;
        do_reset();
        send_image(0, W2, 1'b0);
        repeat (5) @(negedge clk);
        checks += 3;
        if (b_addr.size() !== 0) begin fails++; $display("FAIL empty_wr_count: got %0d required 0", b_addr.size()); end
        if (load_done !== 1'b1)  begin fails++; $display("FAIL empty_load_done: got %b required 1", load_done); end
        if (!rise_seen || rise_edge !== last_edge + 1 + CS) begin
            fails++;
            $display("FAIL empty_cpu_release: seen=%0d edge %0d required %0d", rise_seen, rise_edge, last_edge + 1 + CS);
        end
    endtask

    task automatic test_stall();
        sel = 1'b0;
        do_reset();
        send_image(2, W2, 1'b1);
        repeat (5) @(negedge clk);
        check_two_words("stall");
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        // Exactly fills a 4-word iMem: no overflow.
        do_reset();
        send_image(4, W5, 1'b0);
        repeat (5) @(negedge clk);
        checks += 3;
        if (s_addr.size() !== 4) begin fails++; $display("FAIL fill4_wr_count: got %0d required 4", s_addr.size()); end
        if (s_ovf !== 1'b0)      begin fails++; $display("FAIL fill4_ovf: got %b required 0", s_ovf); end
        if (s_load_done !== 1'b1) begin fails++; $display("FAIL fill4_load_done: got %b required 1", s_load_done); end

        do_reset();
        send_image(5, W5, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (s_addr.size() !== 4) begin
            fails++;
            $display("FAIL ovf_wr_count: got %0d required 4", s_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (s_addr[i] !== 2'(i)) begin fails++; $display("FAIL ovf_addr%0d: got %0d required %0d", i, s_addr[i], i); end
                if (s_data[i] !== W5[i]) begin fails++; $display("FAIL ovf_data%0d: got %08h required %08h", i, s_data[i], W5[i]); end
            end
        end
        checks += 5;
        if (s_ovf !== 1'b1)        begin fails++; $display("FAIL ovf_flag: got %b required 1", s_ovf); end
        if (s_load_done !== 1'b1)  begin fails++; $display("FAIL ovf_load_done: got %b required 1", s_load_done); end
        if (s_imem_addr !== 2'd3)  begin fails++; $display("FAIL ovf_addr_hold: got %0d required 3", s_imem_addr); end
        if (s_cpu_resetn !== 1'b1) begin fails++; $display("FAIL ovf_cpu_resetn: got %b required 1", s_cpu_resetn); end
        if (ovf !== 1'b0)          begin fails++; $display("FAIL ovf_big_flag: got %b required 0", ovf); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        sel = 1'b0;
        do_reset();
        xsum = 8'h00;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        checks += 4;
        if (rise_seen !== 1'b0)  begin fails++; $display("FAIL mid_cpu_held: got released required held"); end
        if (cpu_resetn !== 1'b0) begin fails++; $display("FAIL mid_cpu_resetn: got %b required 0", cpu_resetn); end
        if (imem_we !== 1'b0)    begin fails++; $display("FAIL mid_imem_we: got %b required 0", imem_we); end
        if (in_ready !== 1'b1)   begin fails++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
        do_reset();
        send_image(2, W2, 1'b0);
        repeat (5) @(negedge clk);
        check_two_words("reload");
    endtask

`ifdef IMEM_BOOT_CSUM_EN
    task automatic test_csum();
        logic [7:0] img [6];
        img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        send_byte(8'h05);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks += 4;
        if (load_done !== 1'b1)  begin fails++; $display("FAIL csum_ok_done: got %b required 1", load_done); end
        if (load_err !== 1'b0)   begin fails++; $display("FAIL csum_ok_err: got %b required 0", load_err); end
        if (cpu_resetn !== 1'b1) begin fails++; $display("FAIL csum_ok_cpu: got %b required 1", cpu_resetn); end
        if (b_data.size() !== 1 || b_data[0] !== 32'h01020304) begin
            fails++; $display("FAIL csum_ok_write: got %0d writes required one of 01020304", b_data.size());
        end

        do_reset();
        for (int i = 0; i < 6; i++) send_byte(img[i]);
        send_byte(8'h06);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks += 5;
        if (load_err !== 1'b1)   begin fails++; $display("FAIL csum_bad_err: got %b required 1", load_err); end
        if (load_done !== 1'b0)  begin fails++; $display("FAIL csum_bad_done: got %b required 0", load_done); end
        if (cpu_resetn !== 1'b0) begin fails++; $display("FAIL csum_bad_cpu: got %b required 0", cpu_resetn); end
        if (in_ready !== 1'b0)   begin fails++; $display("FAIL csum_bad_ready: got %b required 0", in_ready); end
        if (b_data.size() !== 1) begin fails++; $display("FAIL csum_bad_write_stands: got %0d required 1", b_data.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_empty();
        test_stall();
        test_overflow();
        test_reset_mid_load();
`ifdef IMEM_BOOT_CSUM_EN
        test_csum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
